alu_cmd_sequencer: RTL and testbench

- Upstream feeder stage for the combinational 2-bit ALU.
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Issues each command to the ALU inputs from registers, captures the 2-bit ALU output one cycle later, and presents it downstream with a valid/ready handshake.
- Flags unsupported opcodes 110 and 111 without issuing them.

---
 rtl/alu_cmd_sequencer.sv | 166 ++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue FSM that feeds a combinational 2-bit ALU and returns results over valid/ready.
// Optional ALU_SEQ_STATS_EN adds saturating handshake/error counters (stat_cmds, stat_errs).
module alu_cmd_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_a,
    input  logic [1:0]               cmd_b,
    input  logic [2:0]               cmd_op,
    output logic [1:0]               alu_a,
    output logic [1:0]               alu_b,
    output logic [2:0]               alu_op,
    input  logic [1:0]               alu_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [1:0]               res_data,
    output logic [2:0]               res_op,
    output logic                     res_err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_level
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [7:0]               stat_cmds,
    output logic [7:0]               stat_errs
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [6:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [LVL_W-1:0] count;
    logic             full, empty, push, pop, capture;
    logic [6:0]       head;
    logic [2:0]       head_op;
    logic             head_err;

    // Issue-stage copies: the popped opcode and error flag survive even when
    // the ALU registers are left untouched for an unsupported opcode.
    logic [2:0]       op_p1;
    logic             err_p1;

    assign full       = (count == FULL_LVL);
    assign empty      = (count == '0);
    assign cmd_ready  = !full;
    assign push       = cmd_valid && !full;
    assign fifo_level = count;
    assign head       = mem[rd_ptr];
    assign head_op    = head[6:4];
    assign head_err   = head_op[2] & head_op[1];
    assign res_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE) || !empty;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---- FIFO storage (p0) ----
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {cmd_op, cmd_a, cmd_b};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ---- issue stage (p1): drive the ALU from registers ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_op <= '0;
            op_p1  <= '0;
            err_p1 <= 1'b0;
        end else if (pop) begin
            op_p1  <= head_op;
            err_p1 <= head_err;
            if (!head_err) begin
                alu_a  <= head[3:2];
                alu_b  <= head[1:0];
                alu_op <= head_op;
            end
        end
    end

    // ---- result stage (p2): capture ALU output, held through HOLD ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_data <= '0;
            res_op   <= '0;
            res_err  <= 1'b0;
        end else if (capture) begin
            res_data <= err_p1 ? 2'b00 : alu_out;
            res_op   <= op_p1;
            res_err  <= err_p1;
        end
    end

`ifdef ALU_SEQ_STATS_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic hs;
    assign hs = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cmds <= '0;
            stat_errs <= '0;
        end else if (hs) begin
            stat_cmds <= sat_inc(stat_cmds);
            if (res_err) stat_errs <= sat_inc(stat_errs);
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with an (a+b) mod 4 ALU model.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_a, cmd_b;
    logic [2:0] cmd_op;
    logic [1:0] alu_a, alu_b;
    logic [2:0] alu_op;
    logic [1:0] alu_out;
    logic       res_valid;
    logic       res_ready;
    logic [1:0] res_data;
    logic [2:0] res_op;
    logic       res_err;
    logic       busy;
    logic [2:0] fifo_level;
`ifdef ALU_SEQ_STATS_EN
    logic [7:0] stat_cmds, stat_errs;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign alu_out = alu_a + alu_b;

    alu_cmd_sequencer #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .cmd_op     (cmd_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_op     (res_op),
        .res_err    (res_err),
        .busy       (busy),
        .fifo_level (fifo_level)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_cmds  (stat_cmds),
        .stat_errs  (stat_errs)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] a, input logic [1:0] b, input logic [2:0] op);
        cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cmd_valid = 1'b0; res_ready = 1'b1;
        cmd_a = '0; cmd_b = '0; cmd_op = '0;
        step(); step();
        rst_n = 1'b1;
        step();
        n_cmp++; if (cmd_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        n_cmp++; if (fifo_level !== 3'd0)    begin n_fail++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (res_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_res_valid got %b want 0", res_valid); end
        n_cmp++; if ({alu_a, alu_b, alu_op} !== 7'd0) begin n_fail++; $display("FAIL reset_alu_regs got %b want 0", {alu_a, alu_b, alu_op}); end
        n_cmp++; if ({res_data, res_op, res_err} !== 6'd0) begin n_fail++; $display("FAIL reset_res_regs got %b want 0", {res_data, res_op, res_err}); end
    endtask

    task automatic test_single();
        res_ready = 1'b1;
        push_one(2'b01, 2'b10, 3'b000);              // edge E
        n_cmp++; if (fifo_level !== 3'd1) begin n_fail++; $display("FAIL single_level_E got %0d want 1", fifo_level); end
        n_cmp++; if (busy !== 1'b1)       begin n_fail++; $display("FAIL single_busy_E got %b want 1", busy); end
        step();                                      // E+1
        n_cmp++; if (alu_a !== 2'b01 || alu_b !== 2'b10) begin n_fail++; $display("FAIL single_alu_ops got a=%b b=%b want a=01 b=10", alu_a, alu_b); end
        n_cmp++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL single_valid_E1 got %b want 0", res_valid); end
        step();                                      // E+2
        n_cmp++; if (res_valid !== 1'b1)  begin n_fail++; $display("FAIL single_valid_E2 got %b want 1", res_valid); end
        n_cmp++; if (res_data !== 2'b11)  begin n_fail++; $display("FAIL single_data got %b want 11", res_data); end
        n_cmp++; if (res_op !== 3'b000 || res_err !== 1'b0) begin n_fail++; $display("FAIL single_op_err got op=%b err=%b want op=000 err=0", res_op, res_err); end
        step();                                      // E+3
        n_cmp++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL single_valid_E3 got %b want 0", res_valid); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL single_busy_E3 got %b want 0", busy); end
    endtask

    task automatic test_invalid();
        res_ready = 1'b1;
        push_one(2'b00, 2'b01, 3'b011);
        step(); step(); step();
        n_cmp++; if (alu_op !== 3'b011)   begin n_fail++; $display("FAIL inv_setup_op got %b want 011", alu_op); end
        push_one(2'b11, 2'b00, 3'b110);              // edge E
        step();                                      // E+1
        n_cmp++; if (alu_op !== 3'b011)   begin n_fail++; $display("FAIL inv_alu_op_kept got %b want 011", alu_op); end
        n_cmp++; if (alu_a !== 2'b00 || alu_b !== 2'b01) begin n_fail++; $display("FAIL inv_alu_ab_kept got a=%b b=%b want a=00 b=01", alu_a, alu_b); end
        step();                                      // E+2
        n_cmp++; if (res_valid !== 1'b1)  begin n_fail++; $display("FAIL inv_valid got %b want 1", res_valid); end
        n_cmp++; if (res_err !== 1'b1)    begin n_fail++; $display("FAIL inv_err got %b want 1", res_err); end
        n_cmp++; if (res_data !== 2'b00)  begin n_fail++; $display("FAIL inv_data got %b want 00", res_data); end
        n_cmp++; if (res_op !== 3'b110)   begin n_fail++; $display("FAIL inv_op got %b want 110", res_op); end
        step();
    endtask

    task automatic test_fill_backpressure();
        int lvl_tab[6] = '{0, 1, 1, 2, 3, 4};
        int got;
        int guard;
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_a = 2'b11; cmd_b = 2'b00; cmd_op = 3'(i); cmd_valid = 1'b1;
            n_cmp++; if (fifo_level !== 3'(lvl_tab[i])) begin n_fail++; $display("FAIL fill_level[%0d] got %0d want %0d", i, fifo_level, lvl_tab[i]); end
            n_cmp++; if (cmd_ready !== (i != 5))        begin n_fail++; $display("FAIL fill_ready[%0d] got %b want %b", i, cmd_ready, (i != 5)); end
            step();
        end
        cmd_valid = 1'b0;
        step(); step();
        n_cmp++; if (fifo_level !== 3'd4) begin n_fail++; $display("FAIL fill_level_held got %0d want 4", fifo_level); end
        n_cmp++; if (res_valid !== 1'b1 || res_op !== 3'b000) begin n_fail++; $display("FAIL fill_hold got valid=%b op=%b want valid=1 op=000", res_valid, res_op); end
        res_ready = 1'b1;
        got = 0;
        guard = 0;
        while (got < 5 && guard < 40) begin
            if (res_valid === 1'b1) begin
                n_cmp++; if (res_op !== 3'(got) || res_data !== 2'b11 || res_err !== 1'b0) begin
                    n_fail++; $display("FAIL drain[%0d] got op=%b data=%b err=%b want op=%b data=11 err=0", got, res_op, res_data, res_err, 3'(got));
                end
                got++;
            end
            step();
            guard++;
        end
        n_cmp++; if (got !== 5) begin n_fail++; $display("FAIL drain_count got %0d want 5", got); end
        got = 0;
        for (int k = 0; k < 10; k++) begin
            if (res_valid === 1'b1) got++;
            step();
        end
        n_cmp++; if (got !== 0) begin n_fail++; $display("FAIL drain_extra got %0d extra results want 0", got); end
        n_cmp++; if (fifo_level !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle got level=%0d busy=%b want 0/0", fifo_level, busy); end
    endtask

    task automatic test_reset_mid();
        int seen;
        res_ready = 1'b0;
        cmd_a = 2'b10; cmd_b = 2'b01; cmd_valid = 1'b1;
        cmd_op = 3'b001; step();
        cmd_op = 3'b010; step();
        cmd_op = 3'b011; step();
        cmd_valid = 1'b0;
        n_cmp++; if (fifo_level !== 3'd2 || res_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup got level=%0d valid=%b want 2/1", fifo_level, res_valid); end
        rst_n = 1'b0;
        step();
        n_cmp++; if (res_valid !== 1'b0)  begin n_fail++; $display("FAIL rstmid_valid got %b want 0", res_valid); end
        n_cmp++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
        n_cmp++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
        rst_n = 1'b1;
        res_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (res_valid === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL rstmid_stale got %0d results want 0", seen); end
    endtask

`ifdef ALU_SEQ_STATS_EN
    task automatic test_stats();
        res_ready = 1'b1;
        push_one(2'b01, 2'b01, 3'b000);
        push_one(2'b10, 2'b01, 3'b100);
        push_one(2'b11, 2'b11, 3'b111);
        push_one(2'b00, 2'b11, 3'b101);
        for (int k = 0; k < 20; k++) step();
        n_cmp++; if (stat_cmds !== 8'd4) begin n_fail++; $display("FAIL stat_cmds got %0d want 4", stat_cmds); end
        n_cmp++; if (stat_errs !== 8'd1) begin n_fail++; $display("FAIL stat_errs got %0d want 1", stat_errs); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_invalid();
        test_fill_backpressure();
        test_reset_mid();
`ifdef ALU_SEQ_STATS_EN
        test_stats();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
